// File: rtl/sa_result_drain_if.sv
// sa_result_drain_if
//   Result stream from the drain stage to the writeback logic.
//   Handshake: a beat transfers on every rising edge where m_valid and
//   m_ready are both 1. Once m_valid is raised it stays high, and m_data,
//   m_row and m_last stay unchanged, until that transfer happens. m_ready may
//   change freely.
//   Signals:
//     m_valid  beat valid (master -> slave)
//     m_ready  beat accepted (slave -> master)
//     m_data   DW-bit result word
//     m_row    source row of m_data
//     m_last   final beat of the frame
interface sa_result_drain_if #(
    parameter int ROWS = 8,
    parameter int DW   = 32
);
    localparam int RW = $clog2(ROWS);

    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [RW-1:0] m_row;
    logic          m_last;

    modport master (output m_valid, output m_data, output m_row, output m_last, input m_ready);
    modport slave  (input m_valid, input m_data, input m_row, input m_last, output m_ready);
endinterface

// File: rtl/sa_result_drain.sv
// sa_result_drain
//   Captures the per-row results presented by the systolic core, acknowledges
//   them with a one-cycle outread pulse, then streams the captured rows in
//   ascending row order on a valid/ready interface. Counts drained frames.
//   Ports:
//     clk, rst     clock, asynchronous active-high reset
//     routport     per-row result words from the core
//     rvalidport   per-row valids from the core (held until outread)
//     outread      one-cycle acknowledge to the core
//     m            result stream (master side)
//     frame_cnt    completed frames, wraps
//     busy         high whenever not IDLE
//     dbg_state    current FSM state for debug/observation
module sa_result_drain #(
    parameter int ROWS  = 8,
    parameter int DW    = 32,
    parameter int CNT_W = 16,
    localparam int RW   = $clog2(ROWS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ROWS-1:0][DW-1:0]   routport,
    input  logic [ROWS-1:0]           rvalidport,
    output logic                      outread,
    sa_result_drain_if.master         m,
    output logic [CNT_W-1:0]          frame_cnt,
    output logic                      busy,
    output logic [1:0]                dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACK  = 2'd1,
        S_SEND = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ROWS-1:0]   mask_q, mask_d;
    logic [DW-1:0]     bank_q [ROWS];
    logic [DW-1:0]     bank_d [ROWS];
    logic [RW-1:0]     row_q, row_d;
    logic [DW-1:0]     data_q, data_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RW-1:0]     hi_row;
    logic [RW-1:0]     pick_row;

    // Lowest set bit of msk at index >= start (0 if none).
    function automatic logic [RW-1:0] lowest_from(input logic [ROWS-1:0] msk, input int start);
        logic [RW-1:0] r;
        r = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (msk[i] && (i >= start)) r = RW'(i);
        end
        return r;
    endfunction

    // Highest set bit of msk (0 if none).
    function automatic logic [RW-1:0] highest(input logic [ROWS-1:0] msk);
        logic [RW-1:0] r;
        r = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (msk[i]) r = RW'(i);
        end
        return r;
    endfunction

    assign hi_row = highest(mask_q);

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        bank_d   = bank_q;
        row_d    = row_q;
        data_d   = data_q;
        valid_d  = valid_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        pick_row = '0;

        case (state_q)
            S_IDLE: begin
                if (|rvalidport) begin
                    // Only rows that are valid are written; the rest keep stale
                    // contents that the mask keeps us from ever sending.
                    for (int i = 0; i < ROWS; i++) begin
                        if (rvalidport[i]) bank_d[i] = routport[i];
                    end
                    mask_d  = rvalidport;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                pick_row = lowest_from(mask_q, 0);
                row_d    = pick_row;
                data_d   = bank_q[pick_row];
                last_d   = (pick_row == hi_row);
                valid_d  = 1'b1;
                state_d  = S_SEND;
            end
            S_SEND: begin
                if (valid_q && m.m_ready) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        mask_d  = '0;
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = S_IDLE;
                    end else begin
                        // Next beat is the next set row above the current one,
                        // preloaded so the stream runs one beat per cycle.
                        pick_row = lowest_from(mask_q, int'(row_q) + 1);
                        row_d    = pick_row;
                        data_d   = bank_q[pick_row];
                        last_d   = (pick_row == hi_row);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            mask_q  <= '0;
            row_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
            for (int i = 0; i < ROWS; i++) bank_q[i] <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            row_q   <= row_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < ROWS; i++) bank_q[i] <= bank_d[i];
        end
    end

    // Pure decodes of flops: no input reaches an output combinationally.
    assign outread   = (state_q == S_ACK);
    assign busy      = (state_q != S_IDLE);
    assign dbg_state = state_q;
    assign frame_cnt = cnt_q;
    assign m.m_valid = valid_q;
    assign m.m_data  = data_q;
    assign m.m_row   = row_q;
    assign m.m_last  = last_q;

endmodule

// File: tb/tb_sa_result_drain.sv
module tb_sa_result_drain;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [7:0][31:0]     routport;
    logic [7:0]           rvalidport;
    logic                 outread;
    logic [15:0]          frame_cnt;
    logic                 busy;
    logic [1:0]           dbg_state;

    logic [7:0][31:0]     w_routport;
    logic [7:0]           w_rvalidport;
    logic                 w_outread;
    logic [1:0]           w_frame_cnt;
    logic                 w_busy;
    logic [1:0]           w_dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [2:0] exp_q[$];

    sa_result_drain_if #(.ROWS(8), .DW(32)) m_if ();
    sa_result_drain_if #(.ROWS(8), .DW(32)) w_if ();

    sa_result_drain #(.ROWS(8), .DW(32), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .routport   (routport),
        .rvalidport (rvalidport),
        .outread    (outread),
        .m          (m_if.master),
        .frame_cnt  (frame_cnt),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    sa_result_drain #(.ROWS(8), .DW(32), .CNT_W(2)) dut_wrap (
        .clk        (clk),
        .rst        (rst),
        .routport   (w_routport),
        .rvalidport (w_rvalidport),
        .outread    (w_outread),
        .m          (w_if.master),
        .frame_cnt  (w_frame_cnt),
        .busy       (w_busy),
        .dbg_state  (w_dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- driver: one whole frame on the main DUT ----------------
    // Called at a negedge; leaves at the negedge where the DUT is back in IDLE.
    task automatic run_frame(input string tag, input logic [7:0] mask, input int base,
                             input bit bp, input bit hold, input int exp_beats,
                             input int exp_last, input int exp_send, input int exp_cnt);
        int         cyc;
        int         sends;
        int         beats;
        bit         stalled;
        logic [2:0] snap_row;
        logic [31:0] snap_data;
        logic       snap_last;
        logic [2:0] er;

        exp_q.delete();
        for (int i = 0; i < 8; i++) if (mask[i]) exp_q.push_back(3'(i));

        for (int i = 0; i < 8; i++) routport[i] = 32'(base + i);
        rvalidport  = mask;
        m_if.m_ready = 1'b0;

        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!outread && cyc < 20);
        check({tag, "_outread_latency"}, cyc, 1);
        if (!outread) return;
        if (!hold) rvalidport = '0;

        @(negedge clk);
        check({tag, "_outread_single"}, {31'd0, outread}, 0);
        check({tag, "_first_valid"}, {31'd0, m_if.m_valid}, 1);

        sends   = 0;
        beats   = 0;
        stalled = 0;
        snap_row = '0; snap_data = '0; snap_last = 1'b0;
        while (m_if.m_valid && sends < 40) begin
            check({tag, "_no_outread_in_send"}, {31'd0, outread}, 0);
            if (stalled) begin
                check({tag, "_hold_row"},  {29'd0, m_if.m_row}, {29'd0, snap_row});
                check({tag, "_hold_data"}, m_if.m_data, snap_data);
                check({tag, "_hold_last"}, {31'd0, m_if.m_last}, {31'd0, snap_last});
            end
            m_if.m_ready = bp ? ((sends % 2) == 1) : 1'b1;
            if (m_if.m_ready) begin
                if (exp_q.size() == 0) begin
                    check({tag, "_extra_beat_row"}, {29'd0, m_if.m_row}, 32'hFFFF_FFFF);
                end else begin
                    er = exp_q.pop_front();
                    check({tag, "_row"},  {29'd0, m_if.m_row}, {29'd0, er});
                    check({tag, "_data"}, m_if.m_data, 32'(base + int'(er)));
                    check({tag, "_last"}, {31'd0, m_if.m_last}, {31'd0, (int'(er) == exp_last)});
                end
                beats++;
                stalled = 0;
            end else begin
                snap_row  = m_if.m_row;
                snap_data = m_if.m_data;
                snap_last = m_if.m_last;
                stalled   = 1;
            end
            sends++;
            @(negedge clk);
        end
        m_if.m_ready = 1'b0;
        check({tag, "_beats"}, beats, exp_beats);
        check({tag, "_send_cycles"}, sends, exp_send);
        check({tag, "_frame_cnt"}, {16'd0, frame_cnt}, exp_cnt);
        check({tag, "_busy_after"}, {31'd0, busy}, 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0] mask;
        int         base;
        bit         bp;
        int         exp_beats;
        int         exp_last;
        int         exp_send;
        int         exp_cnt;
    } vec_t;

    vec_t vecs[5];
    int   exp_wrap[5];

    initial begin
        int cyc;

        vecs[0] = '{mask: 8'hFF,        base: 100,   bp: 0, exp_beats: 8, exp_last: 7, exp_send: 8,  exp_cnt: 1};
        vecs[1] = '{mask: 8'b1010_0100, base: 'hA0,  bp: 0, exp_beats: 3, exp_last: 7, exp_send: 3,  exp_cnt: 2};
        vecs[2] = '{mask: 8'hFF,        base: 100,   bp: 1, exp_beats: 8, exp_last: 7, exp_send: 16, exp_cnt: 3};
        vecs[3] = '{mask: 8'h01,        base: 50,    bp: 0, exp_beats: 1, exp_last: 0, exp_send: 1,  exp_cnt: 4};
        vecs[4] = '{mask: 8'h80,        base: 300,   bp: 0, exp_beats: 1, exp_last: 7, exp_send: 1,  exp_cnt: 5};
        exp_wrap = '{1, 2, 3, 0, 1};

        // ---- reset ----
        rst          = 1'b1;
        routport     = '0;
        rvalidport   = '0;
        m_if.m_ready = 1'b0;
        w_routport   = '0;
        w_rvalidport = '0;
        w_if.m_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_outread",   {31'd0, outread}, 0);
        check("rst_m_valid",   {31'd0, m_if.m_valid}, 0);
        check("rst_m_last",    {31'd0, m_if.m_last}, 0);
        check("rst_m_row",     {29'd0, m_if.m_row}, 0);
        check("rst_m_data",    m_if.m_data, 0);
        check("rst_frame_cnt", {16'd0, frame_cnt}, 0);
        check("rst_busy",      {31'd0, busy}, 0);
        check("rst_state",     {30'd0, dbg_state}, 0);
        check("rst_wrap_cnt",  {30'd0, w_frame_cnt}, 0);
        rst = 1'b0;
        @(negedge clk);

        // ---- counter wrap on the 2-bit-counter instance ----
        for (int k = 0; k < 5; k++) begin
            w_routport[3] = 32'(k);
            w_rvalidport  = 8'h08;
            w_if.m_ready  = 1'b1;
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!w_outread && cyc < 20);
            check("wrap_outread", {31'd0, w_outread}, 1);
            w_rvalidport = '0;
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (w_busy && cyc < 20);
            check("wrap_busy", {31'd0, w_busy}, 0);
            check("wrap_cnt", {30'd0, w_frame_cnt}, exp_wrap[k]);
        end
        w_if.m_ready = 1'b0;

        // ---- table-driven frames ----
        for (int k = 0; k < 5; k++) begin
            run_frame($sformatf("tbl%0d", k), vecs[k].mask, vecs[k].base, vecs[k].bp, 1'b0,
                      vecs[k].exp_beats, vecs[k].exp_last, vecs[k].exp_send, vecs[k].exp_cnt);
            @(negedge clk);
        end

        // ---- overlap: valids held through SEND, then a second frame ----
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("ovl_cnt_cleared", {16'd0, frame_cnt}, 0);
        run_frame("ovl1", 8'hFF, 100, 1'b0, 1'b1, 8, 7, 8, 1);
        run_frame("ovl2", 8'hFF, 200, 1'b0, 1'b0, 8, 7, 8, 2);
        @(negedge clk);

        // ---- reset in the middle of SEND ----
        for (int i = 0; i < 8; i++) routport[i] = 32'(100 + i);
        rvalidport   = 8'hFF;
        m_if.m_ready = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!outread && cyc < 20);
        check("mid_outread", {31'd0, outread}, 1);
        @(negedge clk);
        m_if.m_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("mid_row", {29'd0, m_if.m_row}, k);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        check("mid_rst_m_valid", {31'd0, m_if.m_valid}, 0);
        check("mid_rst_m_row",   {29'd0, m_if.m_row}, 0);
        check("mid_rst_m_data",  m_if.m_data, 0);
        check("mid_rst_m_last",  {31'd0, m_if.m_last}, 0);
        check("mid_rst_outread", {31'd0, outread}, 0);
        check("mid_rst_busy",    {31'd0, busy}, 0);
        check("mid_rst_cnt",     {16'd0, frame_cnt}, 0);
        @(negedge clk);
        check("mid_rst_hold_valid", {31'd0, m_if.m_valid}, 0);
        rst = 1'b0;
        run_frame("recap", 8'hFF, 100, 1'b0, 1'b0, 8, 7, 8, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
